// File: rtl/twos_complementor.sv
// twos_complementor: registered two's-complement negation built on a two-level carry-lookahead incrementer
module twos_complementor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] compA,
  output logic             out_valid,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / 4;
  localparam int NS = (NG + 3) / 4;
  logic [WIDTH-1:0] inverted, carry, result;
  logic [4*NS-1:0] grpProp;
  logic [NS-1:0] superProp, superCarry;
  logic [NG-1:0] grpCarry;
  logic carryOut;
  assign inverted = ~A;
  // Missing groups in the last super-group are padded as transparent (propagate=1)
  always_comb begin
    grpProp = '1;
    for (int g = 0; g < NG; g++) grpProp[g] = &inverted[4*g +: 4];
  end
  genvar s, j, k;
  for (s = 0; s < NS; s++) begin : gSuper
    assign superProp[s] = &grpProp[4*s +: 4];
    if (s == 0) begin : gFirst
      assign superCarry[s] = 1'b1;
    end else begin : gRest
      assign superCarry[s] = &superProp[s-1:0];
    end
    for (j = 0; j < 4; j++) begin : gGrp
      if (4*s + j < NG) begin : gUsed
        if (j == 0) begin : gLead
          assign grpCarry[4*s] = superCarry[s];
        end else begin : gTail
          assign grpCarry[4*s+j] = superCarry[s] & (&grpProp[4*s+j-1:4*s]);
        end
        for (k = 0; k < 4; k++) begin : gBit
          if (k == 0) begin : gB0
            assign carry[4*(4*s+j)] = grpCarry[4*s+j];
          end else begin : gBn
            assign carry[4*(4*s+j)+k] = grpCarry[4*s+j] & (&inverted[4*(4*s+j)+k-1:4*(4*s+j)]);
          end
        end
      end
    end
  end
  assign carryOut = superCarry[NS-1] & superProp[NS-1];
  assign result = inverted ^ carry;
  // Carry into the MSB means all lower bits are zero; the carry out means A itself is zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compA     <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        compA <= result;
        ovf   <= A[WIDTH-1] & carry[WIDTH-1];
        zero  <= carryOut;
      end
    end
  end
endmodule

// File: tb/tb_twos_complementor.sv
// tb_twos_complementor: directed table, handshake, async reset and random involution checks
module tb_twos_complementor;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [31:0] A, compA;
  logic out_valid, ovf, zero;
  int unsigned passed = 0;
  int unsigned total = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
    logic        eovf;
    logic        ezero;
  } vec_t;
  vec_t vecs[9];
  twos_complementor #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A),
    .compA(compA), .out_valid(out_valid), .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] negRef(input logic [31:0] a);
    return 32'(33'h1_0000_0000 - {1'b0, a});
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h, required %h", name, got, want);
  endtask
  task automatic drive(input logic v, input logic [31:0] a);
    @(negedge clk);
    in_valid = v;
    A = a;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] held, r, c;
    vecs[0] = '{32'hCCC9CCC9, 32'h33363337, 1'b0, 1'b0};
    vecs[1] = '{32'h327339C9, 32'hCD8CC637, 1'b0, 1'b0};
    vecs[2] = '{32'hF27339C9, 32'h0D8CC637, 1'b0, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[6] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[7] = '{32'h00000010, 32'hFFFFFFF0, 1'b0, 1'b0};
    vecs[8] = '{32'h00010000, 32'hFFFF0000, 1'b0, 1'b0};
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_compA", compA, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_ovf", {31'b0, ovf}, 32'h0);
    check("reset_zero", {31'b0, zero}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a);
      check($sformatf("vec%0d_compA", i), compA, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].eovf});
      check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].ezero});
    end
    drive(1'b1, 32'h12345678);
    check("hs_valid0", {31'b0, out_valid}, 32'h1);
    check("hs_comp0", compA, 32'hEDCBA988);
    held = compA;
    drive(1'b0, 32'hDEADBEEF);
    check("hs_idle_valid", {31'b0, out_valid}, 32'h0);
    check("hs_idle_hold", compA, 32'hEDCBA988);
    drive(1'b1, 32'h00000003);
    check("hs_valid2", {31'b0, out_valid}, 32'h1);
    check("hs_comp2", compA, 32'hFFFFFFFD);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_compA", compA, 32'h0);
    check("async_valid", {31'b0, out_valid}, 32'h0);
    check("async_ovf", {31'b0, ovf}, 32'h0);
    check("async_zero", {31'b0, zero}, 32'h0);
    drive(1'b1, 32'h00000005);
    check("rst_drop_compA", compA, 32'h0);
    check("rst_drop_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", {31'b0, out_valid}, 32'h0);
    check("post_rst_idle_comp", compA, 32'h0);
    drive(1'b1, 32'h00000005);
    check("post_rst_comp", compA, 32'hFFFFFFFB);
    check("post_rst_valid", {31'b0, out_valid}, 32'h1);
    for (int i = 0; i < 10000; i++) begin
      r = $urandom;
      if (i % 1000 == 0) r = 32'h80000000 >> (i / 1000);
      drive(1'b1, r);
      c = compA;
      check("rand_comp", c, negRef(r));
      check("rand_flags", {30'b0, ovf, zero}, {30'b0, r == 32'h80000000, r == 32'h0});
      drive(1'b1, c);
      check("rand_invol", compA, r);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/twos_complementor.md
Name: twos_complementor

Overview:
- Registered 32-bit two's-complement negation unit used by the KGP-RISC ALU datapath, e.g. for SUB/compare paths.
- Produces compA = (~A + 1) mod 2^32 one clock after A is presented.
- Also produces overflow and zero status flags.
- The increment is built from 4-bit carry-lookahead groups chained by a group-level lookahead tree, not a behavioural "+".

Parameters:
- WIDTH, 32, operand width; must be a multiple of 4; all tests use 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  A is sampled on this edge when high
- A  input  WIDTH  operand, treated as a two's-complement number
- compA  output  WIDTH  registered two's complement of the last valid A
- out_valid  output  1  high for exactly the cycle after an accepted A
- ovf  output  1  operand was the most-negative value (1 followed by WIDTH-1 zeros); result equals the input
- zero  output  1  result is zero (operand was 0)

Behaviour:
- Reset: while rst=1, independent of clk, compA=0, out_valid=0, ovf=0, zero=0. These values hold until the first accepted operand after rst is released.
- Datapath, combinational:
  - inverted[i] = ~A[i]
  - increment carry-in = 1
  - bit result r[i] = inverted[i] XOR c[i], where c[0]=1 and c[i+1] = c[i] AND inverted[i]. Equivalently, r[i] = A[i] XOR (OR of A[i-1:0]).
- Carry structure:
  - Per 4-bit group: generate-free propagate P = AND of the 4 inverted bits.
  - Group carries are computed by a two-level lookahead over the WIDTH/4 groups (groups of 4 again).
  - Carry out of the MSB is discarded.
- Register stage: on a rising clk edge with in_valid=1:
  - compA <= r
  - ovf <= (A == 1 followed by zeros)
  - zero <= (A == 0)
  - out_valid <= 1
- On a rising edge with in_valid=0: out_valid <= 0; compA, ovf and zero hold their previous values.
- Latency: exactly 1 cycle. Throughput: one operand per cycle; back-to-back valids give back-to-back results.
- Boundary cases:
  - A=0 -> compA=0, zero=1, ovf=0 (the carry ripples through all bits and is dropped).
  - A=0x80000000 -> compA=0x80000000, ovf=1, zero=0.
  - A=0xFFFFFFFF -> compA=0x00000001.
  - A=0x00000001 -> compA=0xFFFFFFFF.
- Reset mid-stream: asserting rst at any time clears outputs immediately. Any operand sampled during reset is lost. The first valid operand after release produces its result the next cycle.
- Involution: feeding compA back in as A returns the original value, for every input.
- No X propagation: outputs are defined from reset onward.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with prior compA nonzero -> compA=0, out_valid=0, ovf=0, zero=0 immediately, before any clk edge.
- Directed vectors, one per cycle with in_valid=1:
  - 0xCCC9CCC9 -> 0x33363337
  - 0x327339C9 -> 0xCD8CC637
  - 0xF27339C9 -> 0x0D8CC637
  - Each appears 1 cycle later with out_valid=1.
- Edge values:
  - 0x00000000 -> 0x00000000, zero=1
  - 0x80000000 -> 0x80000000, ovf=1
  - 0xFFFFFFFF -> 0x00000001
  - 0x00000001 -> 0xFFFFFFFF
- Carry-group boundaries: 0x00000010 -> 0xFFFFFFF0; 0x00010000 -> 0xFFFF0000. Exercises the group and second-level lookahead.
- Handshake: valid, idle, valid pattern -> out_valid pulses 1,0,1. compA holds during the idle cycle.
- Randomized: 10,000 random A values -> compA == (2^32 - A) mod 2^32. Feeding compA back in returns A.
